trivium_byte_cipher: RTL and testbench

//   Downstream stage of the Trivium keystream generator. Packs the serial keystream
//   bit `s` into DATA_W-bit words and buffers them in a small FIFO. XORs each

---
 rtl/trivium_byte_cipher_if.sv | 17 +
 rtl/trivium_byte_cipher.sv | 80 ++++++++
 tb/tb_trivium_byte_cipher.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/trivium_byte_cipher_if.sv
// Byte stream handshake bundle for the Trivium cipher stage: data in, XORed data out.
// The cipher block is the slave; the source/sink side is the master.
interface trivium_byte_cipher_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid);
    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid);
endinterface

// File: rtl/trivium_byte_cipher.sv
// Packs the serial Trivium keystream into words, buffers them in a small FIFO and
// XORs one buffered word onto each accepted data word (encrypt and decrypt alike).
module trivium_byte_cipher #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_ORDER  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sync_clr,
    input  logic                          ks_bit,
    input  logic                          ks_valid,
    trivium_byte_cipher_if.slave          bus,
    output logic [$clog2(FIFO_DEPTH):0]   ks_level,
    output logic                          overflow
);
    localparam int CW = $clog2(DATA_W);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [CW-1:0]     cnt, pos;
    logic [DATA_W-1:0] sreg, word;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              last, full, push_req, push, pop;

    // Word as it will look once the current bit lands; only meaningful when last.
    always_comb begin
        pos       = (BIT_ORDER != 0) ? CW'(DATA_W - 1) - cnt : cnt;
        word      = sreg;
        word[pos] = ks_bit;
    end

    assign last     = (cnt == CW'(DATA_W - 1));
    assign full     = (ks_level == LW'(FIFO_DEPTH));
    assign bus.in_ready = !sync_clr && (ks_level != '0) && (!bus.out_valid || bus.out_ready);
    assign pop      = bus.in_valid && bus.in_ready;
    assign push_req = ks_valid && last && !sync_clr;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            sreg          <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ks_level      <= '0;
            overflow      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (sync_clr) begin
            cnt           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ks_level      <= '0;
            overflow      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (ks_valid) begin
                sreg <= word;
                cnt  <= last ? '0 : cnt + CW'(1);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (push_req && !push) overflow <= 1'b1;
            if (pop) begin
                bus.out_data  <= bus.in_data ^ mem[rd_ptr];
                bus.out_valid <= 1'b1;
                rd_ptr        <= rd_ptr + AW'(1);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            ks_level <= ks_level + LW'(push) - LW'(pop);
        end
    end
endmodule

// File: tb/tb_trivium_byte_cipher.sv
// Directed checks of the Trivium byte cipher stage plus an encrypt->decrypt round trip.
module tb_trivium_byte_cipher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_clr = 1'b0, ks_bit = 1'b0, ks_valid = 1'b0;
    logic [7:0] a_in_data = '0;
    logic a_in_valid = 1'b0, a_out_ready = 1'b0, d_out_ready = 1'b0, chain = 1'b0;
    logic [2:0] lvl_a, lvl_b, lvl_d;
    logic ovf_a, ovf_b, ovf_d;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    trivium_byte_cipher_if #(.DATA_W(8)) bus_a ();
    trivium_byte_cipher_if #(.DATA_W(8)) bus_b ();
    trivium_byte_cipher_if #(.DATA_W(8)) bus_d ();

    assign bus_a.in_data   = a_in_data;
    assign bus_a.in_valid  = a_in_valid;
    assign bus_a.out_ready = chain ? bus_d.in_ready : a_out_ready;
    assign bus_b.in_data   = a_in_data;
    assign bus_b.in_valid  = a_in_valid;
    assign bus_b.out_ready = 1'b1;
    assign bus_d.in_data   = bus_a.out_data;
    assign bus_d.in_valid  = chain && bus_a.out_valid;
    assign bus_d.out_ready = d_out_ready;

    trivium_byte_cipher #(.DATA_W(8), .FIFO_DEPTH(4), .BIT_ORDER(0)) ua (
        .clk(clk), .rst(rst), .sync_clr(sync_clr), .ks_bit(ks_bit), .ks_valid(ks_valid),
        .bus(bus_a), .ks_level(lvl_a), .overflow(ovf_a));
    trivium_byte_cipher #(.DATA_W(8), .FIFO_DEPTH(4), .BIT_ORDER(1)) ub (
        .clk(clk), .rst(rst), .sync_clr(sync_clr), .ks_bit(ks_bit), .ks_valid(ks_valid),
        .bus(bus_b), .ks_level(lvl_b), .overflow(ovf_b));
    trivium_byte_cipher #(.DATA_W(8), .FIFO_DEPTH(4), .BIT_ORDER(0)) ud (
        .clk(clk), .rst(rst), .sync_clr(sync_clr), .ks_bit(ks_bit), .ks_valid(ks_valid),
        .bus(bus_d), .ks_level(lvl_d), .overflow(ovf_d));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // First bit sent is w[0].
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ks_bit   = w[i];
            ks_valid = 1'b1;
            tick();
        end
        ks_valid = 1'b0;
    endtask

    task automatic clr;
        a_in_valid = 1'b0;
        sync_clr   = 1'b1;
        tick();
        sync_clr   = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [7:0] exp);
        a_in_data   = 8'h00;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        tick();
        a_in_valid  = 1'b0;
        chk(tag, bus_a.out_data, exp);
    endtask

    logic [7:0] t3w [5] = '{8'hA5, 8'h3C, 8'h0F, 8'hE1, 8'h77};
    logic [7:0] pt [64];
    logic [7:0] w;

    initial begin
        // reset values with no clock edge yet
        #2;
        chk("rst_out_valid", bus_a.out_valid, 0);
        chk("rst_out_data",  bus_a.out_data, 0);
        chk("rst_level",     lvl_a, 0);
        chk("rst_overflow",  ovf_a, 0);
        chk("rst_in_ready",  bus_a.in_ready, 0);
        #10 rst = 1'b0;

        // 1: bits 1,0,1,1,0,0,0,0 -> 0x0D LSB-first, 0xB0 MSB-first
        send_bits(8'b0000_1101, 8);
        chk("t1_level_a", lvl_a, 1);
        chk("t1_level_b", lvl_b, 1);
        chk("t1_in_ready", bus_a.in_ready, 1);
        a_in_data = 8'hFF; a_in_valid = 1'b1; a_out_ready = 1'b1;
        chk("t1_no_early_valid", bus_a.out_valid, 0);
        tick();
        a_in_valid = 1'b0;
        chk("t1_out_valid", bus_a.out_valid, 1);
        chk("t1_out_lsb",   bus_a.out_data, 8'hF2);
        chk("t1_out_msb",   bus_b.out_data, 8'h4F);
        chk("t1_level0",    lvl_a, 0);
        tick();
        chk("t1_valid_drop", bus_a.out_valid, 0);
        chk("t1_data_keep",  bus_a.out_data, 8'hF2);

        // 2: output hold under backpressure
        clr();
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        chk("t2_level", lvl_a, 2);
        a_out_ready = 1'b0; a_in_data = 8'h00; a_in_valid = 1'b1;
        tick();
        a_in_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_data",  bus_a.out_data, 8'h11);
            chk("t2_hold_valid", bus_a.out_valid, 1);
            chk("t2_hold_rdy",   bus_a.in_ready, 0);
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("t2_next_word",  bus_a.out_data, 8'hDD);
        chk("t2_next_valid", bus_a.out_valid, 1);
        tick();

        // 3: free-running keystream with no consumer
        clr();
        for (int c = 0; c < 40; c++) begin
            w = t3w[c / 8];
            ks_bit = w[c % 8];
            ks_valid = 1'b1;
            tick();
            if (c == 30) chk("t3_level31", lvl_a, 3);
            if (c == 31) chk("t3_level32", lvl_a, 4);
            if (c == 38) chk("t3_ovf39",   ovf_a, 0);
            if (c == 39) chk("t3_ovf40",   ovf_a, 1);
        end
        ks_valid = 1'b0;
        chk("t3_level_full", lvl_a, 4);
        for (int k = 0; k < 4; k++) drain("t3_fifo_word", t3w[k]);
        chk("t3_empty", lvl_a, 0);
        chk("t3_ovf_sticky", ovf_a, 1);

        // 4: push and pop in the same cycle on a full FIFO
        clr();
        send_bits(8'h10, 8); send_bits(8'h20, 8); send_bits(8'h30, 8); send_bits(8'h40, 8);
        chk("t4_full", lvl_a, 4);
        send_bits(8'h50, 7);
        ks_bit = 1'b0; ks_valid = 1'b1;
        a_in_data = 8'h00; a_in_valid = 1'b1; a_out_ready = 1'b1;
        tick();
        ks_valid = 1'b0; a_in_valid = 1'b0;
        chk("t4_no_ovf", ovf_a, 0);
        chk("t4_level",  lvl_a, 4);
        chk("t4_oldest", bus_a.out_data, 8'h10);
        drain("t4_w1", 8'h20);
        drain("t4_w2", 8'h30);
        drain("t4_w3", 8'h40);
        drain("t4_w4", 8'h50);

        // 5: sync_clr mid-word, with a queued word and competing events
        clr();
        send_bits(8'h5A, 8);
        send_bits(8'h07, 3);
        sync_clr = 1'b1; ks_bit = 1'b1; ks_valid = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1;
        chk("t5_clr_rdy", bus_a.in_ready, 0);
        tick();
        sync_clr = 1'b0; ks_valid = 1'b0; a_in_valid = 1'b0;
        chk("t5_level0", lvl_a, 0);
        chk("t5_no_xfer", bus_a.out_valid, 0);
        send_bits(8'h96, 8);
        chk("t5_level1", lvl_a, 1);
        drain("t5_word", 8'h96);

        // async reset mid-stream
        send_bits(8'h33, 8);
        a_out_ready = 1'b0; a_in_data = 8'h00; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("t5_pre_rst_valid", bus_a.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_arst_valid", bus_a.out_valid, 0);
        chk("t5_arst_data",  bus_a.out_data, 0);
        chk("t5_arst_rdy",   bus_a.in_ready, 0);
        #1 rst = 1'b0;

        // 6: encrypt -> decrypt round trip with random throttling
        clr();
        for (int i = 0; i < 64; i++) pt[i] = 8'($urandom);
        chain = 1'b1;
        begin
            int sent = 0, got = 0, cyc = 0;
            logic a_fire;
            while (got < 64 && cyc < 5000) begin
                ks_bit      = 1'($urandom);
                ks_valid    = ($urandom_range(3) != 0) && (lvl_a != 3'd4) && (lvl_d != 3'd4);
                a_in_valid  = (sent < 64) && ($urandom_range(2) != 0);
                a_in_data   = pt[sent % 64];
                d_out_ready = ($urandom_range(3) != 0);
                #2;
                a_fire = a_in_valid && bus_a.in_ready;
                if (bus_d.out_valid && d_out_ready) begin
                    chk("t6_roundtrip", bus_d.out_data, pt[got]);
                    got++;
                end
                tick();
                if (a_fire) sent++;
                cyc++;
            end
            chk("t6_count", got, 64);
        end
        chain = 1'b0; a_in_valid = 1'b0; ks_valid = 1'b0;
        chk("t6_ovf_enc", ovf_a, 0);
        chk("t6_ovf_dec", ovf_d, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
